pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have id_optype  in  6;  id_regaddr1  in  5;  id_regaddr2  in  5;  id_use1  in  1;  id_use2  in  1. These describe the decode-stage instruction and which source operands it reads.
REQ-004 SHALL have alu_optype  in  6  and  alu_regaddr3  in  5. These describe the instruction currently in the ALU stage.
REQ-005 SHALL have br_taken  in  1. It is the branch/jump resolved taken in the ALU stage.
REQ-006 SHALL have mem_busy  in  1. It means the multicycle memory access is in progress.
REQ-007 SHALL have pc_stall, id_stall, alu_stall  out  1  each, meaning hold the PC, ID and ALU pipeline registers respectively.
REQ-008 SHALL have id_bubble, alu_bubble, mem_bubble  out  1  each, meaning load NOP (optype 6'h3F) into ID, ALU and WB input respectively.
REQ-009 SHALL have stall_cnt  out  32  and  flush_cnt  out  16, both saturating performance counters.

Function
REQ-010 SHALL implement state register {RUN, MEMWAIT, FLUSH} plus pending-branch flag br_pend.
REQ-011 SHALL drive all stall/bubble outputs combinationally from the current state, br_pend and the current inputs, so the response lands in the same cycle.
REQ-012 SHALL detect load-use as: alu_optype==OPT_LW, alu_regaddr3!=0, and ((id_use1 && id_regaddr1==alu_regaddr3) || (id_use2 && id_regaddr2==alu_regaddr3)).
REQ-013 SHALL apply this priority in RUN: mem_busy > br_taken > load-use > none.
REQ-014 SHALL, in RUN with mem_busy, assert pc_stall, id_stall, alu_stall and mem_bubble; latch br_pend<=br_taken; next state MEMWAIT.
REQ-015 SHALL, in RUN with br_taken and no mem_busy, assert id_bubble and alu_bubble, with no stalls; next state FLUSH.
REQ-016 SHALL, in RUN with load-use only, assert pc_stall, id_stall and alu_bubble for exactly one cycle; state stays RUN.
REQ-017 SHALL, in MEMWAIT while mem_busy=1, keep the same outputs as REQ-014 and OR br_taken into br_pend.
REQ-018 SHALL, in MEMWAIT when mem_busy=0: if br_pend, assert id_bubble and alu_bubble, clear br_pend and go to FLUSH; else go to RUN with no outputs asserted.
REQ-019 SHALL, in FLUSH, ignore br_taken and load-use because the ALU stage holds a bubble; mem_busy still wins per REQ-014; otherwise go to RUN after 1 cycle.
REQ-020 SHALL never assert a stall and a bubble on the same stage in the same cycle.
REQ-021 SHALL never assert alu_stall without pc_stall and id_stall.
REQ-022 SHALL increment stall_cnt each cycle pc_stall=1, saturating at 32'hFFFF_FFFF.
REQ-023 SHALL increment flush_cnt each cycle id_bubble=1 due to a branch, saturating at 16'hFFFF.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, force state=RUN, br_pend=0, stall_cnt=0, flush_cnt=0.
REQ-025 SHALL, while rst=1, force all stall/bubble outputs to 0 regardless of the inputs.
REQ-026 SHALL let a reset mid-MEMWAIT or mid-FLUSH discard any pending branch.

Structure
REQ-027 SHALL take OPT_LW=6'h10, OPT_NOP=6'h3F, the state encoding and the counter widths from the shared pipeline package.
REQ-028 SHALL contain one sub-module, hazard_detect: combinational load-use compare per REQ-012. The remainder is the FSM and counters.

Verification
REQ-029 Load-use: ALU optype 6'h10, regaddr3=5, ID use1 with regaddr1=5 -> one cycle of pc_stall=id_stall=alu_bubble=1, stall_cnt=1.
REQ-030 Register zero: same stimulus as REQ-029 with regaddr3=0 -> no stall, no bubble.
REQ-031 Branch: br_taken=1 in RUN -> id_bubble=alu_bubble=1 for 1 cycle; br_taken held 2 cycles -> second cycle ignored, flush_cnt=1.
REQ-032 Branch during memory wait: mem_busy=1 for 3 cycles with br_taken=1 in cycle 1 -> 3 stall cycles with mem_bubble=1, then 1 flush cycle; stall_cnt=3, flush_cnt=1.
REQ-033 Reset mid-operation: rst=1 during MEMWAIT with br_pend=1 -> after release, RUN, no flush, counters 0.
REQ-034 Saturation: preload stall_cnt to 32'hFFFF_FFFE, apply 3 stall cycles -> stall_cnt=32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline constants, opcodes and hazard-controller state encoding.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned OPT_W       = 6;
  localparam int unsigned REG_W       = 5;
  localparam int unsigned STALL_CNT_W = 32;
  localparam int unsigned FLUSH_CNT_W = 16;

  localparam logic [OPT_W-1:0] OPT_LW  = 6'h10;
  localparam logic [OPT_W-1:0] OPT_NOP = 6'h3F;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    FLUSH   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; master is the pipeline, slave the controller.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic [OPT_W-1:0]       id_optype;
  logic [REG_W-1:0]       id_regaddr1;
  logic [REG_W-1:0]       id_regaddr2;
  logic                   id_use1;
  logic                   id_use2;
  logic [OPT_W-1:0]       alu_optype;
  logic [REG_W-1:0]       alu_regaddr3;
  logic                   br_taken;
  logic                   mem_busy;
  // Performance-counter preload hook, used to bring stall_cnt near saturation.
  logic                   stall_cnt_load;
  logic [STALL_CNT_W-1:0] stall_cnt_load_val;

  logic                   pc_stall;
  logic                   id_stall;
  logic                   alu_stall;
  logic                   id_bubble;
  logic                   alu_bubble;
  logic                   mem_bubble;

  modport master (
    output id_optype, id_regaddr1, id_regaddr2, id_use1, id_use2,
    output alu_optype, alu_regaddr3, br_taken, mem_busy,
    output stall_cnt_load, stall_cnt_load_val,
    input  pc_stall, id_stall, alu_stall, id_bubble, alu_bubble, mem_bubble
  );

  modport slave (
    input  id_optype, id_regaddr1, id_regaddr2, id_use1, id_use2,
    input  alu_optype, alu_regaddr3, br_taken, mem_busy,
    input  stall_cnt_load, stall_cnt_load_val,
    output pc_stall, id_stall, alu_stall, id_bubble, alu_bubble, mem_bubble
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: decode reads a register the load in the ALU stage will write.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [OPT_W-1:0] alu_optype,
  input  logic [REG_W-1:0] alu_regaddr3,
  input  logic [REG_W-1:0] id_regaddr1,
  input  logic [REG_W-1:0] id_regaddr2,
  input  logic             id_use1,
  input  logic             id_use2,
  output logic             load_use_c
);

  logic src1_hit;
  logic src2_hit;

  assign src1_hit   = id_use1 && (id_regaddr1 == alu_regaddr3);
  assign src2_hit   = id_use2 && (id_regaddr2 == alu_regaddr3);
  // r0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use_c = (alu_optype == OPT_LW) && (alu_regaddr3 != '0) && (src1_hit || src2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: same-cycle stall/bubble decisions plus saturating perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  pipe_hazard_ctrl_if.slave      hz,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [FLUSH_CNT_W-1:0] flush_cnt
);

  state_e state_q, state_d;
  logic   br_pend_q, br_pend_d;
  logic   load_use;
  logic   branch_flush;
  logic   pc_stall, id_stall, alu_stall;
  logic   id_bubble, alu_bubble, mem_bubble;
  logic   unused_nop_decode;

  // Decode optype is not needed for hazard decisions.
  assign unused_nop_decode = (hz.id_optype == OPT_NOP);

  hazard_detect u_hazard_detect (
    .alu_optype   (hz.alu_optype),
    .alu_regaddr3 (hz.alu_regaddr3),
    .id_regaddr1  (hz.id_regaddr1),
    .id_regaddr2  (hz.id_regaddr2),
    .id_use1      (hz.id_use1),
    .id_use2      (hz.id_use2),
    .load_use_c   (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      br_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      br_pend_q <= br_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    br_pend_d    = br_pend_q;
    branch_flush = 1'b0;
    pc_stall     = 1'b0;
    id_stall     = 1'b0;
    alu_stall    = 1'b0;
    id_bubble    = 1'b0;
    alu_bubble   = 1'b0;
    mem_bubble   = 1'b0;
    if (!rst) begin
      if (hz.mem_busy) begin
        // Memory wait freezes everything up to ALU in any state.
        pc_stall   = 1'b1;
        id_stall   = 1'b1;
        alu_stall  = 1'b1;
        mem_bubble = 1'b1;
        state_d    = MEMWAIT;
        unique case (state_q)
          RUN:     br_pend_d = hz.br_taken;
          MEMWAIT: br_pend_d = br_pend_q | hz.br_taken;
          default: br_pend_d = 1'b0;
        endcase
      end else begin
        state_d   = RUN;
        br_pend_d = 1'b0;
        unique case (state_q)
          RUN: begin
            if (hz.br_taken) begin
              branch_flush = 1'b1;
              state_d      = FLUSH;
            end else if (load_use) begin
              pc_stall   = 1'b1;
              id_stall   = 1'b1;
              alu_bubble = 1'b1;
            end
          end
          MEMWAIT: begin
            if (br_pend_q) begin
              branch_flush = 1'b1;
              state_d      = FLUSH;
            end
          end
          default: ;
        endcase
        if (branch_flush) begin
          id_bubble  = 1'b1;
          alu_bubble = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz.stall_cnt_load)
        stall_cnt <= hz.stall_cnt_load_val;
      else if (pc_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      if (branch_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + FLUSH_CNT_W'(1);
    end
  end

  assign hz.pc_stall   = pc_stall;
  assign hz.id_stall   = id_stall;
  assign hz.alu_stall  = alu_stall;
  assign hz.id_bubble  = id_bubble;
  assign hz.alu_bubble = alu_bubble;
  assign hz.mem_bubble = mem_bubble;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic against a rule-level model.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .hz        (hz),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Model: what the pipeline is doing, not how the controller encodes it.
  bit          m_waiting;
  bit          m_flushing;
  bit          m_branch_owed;
  logic [31:0] m_stall;
  logic [15:0] m_flush;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit mb, input bit bt, input logic [5:0] aop,
                       input logic [4:0] r3, input logic [4:0] r1, input logic [4:0] r2,
                       input bit u1, input bit u2);
    rst             = r;
    hz.mem_busy     = mb;
    hz.br_taken     = bt;
    hz.alu_optype   = aop;
    hz.alu_regaddr3 = r3;
    hz.id_regaddr1  = r1;
    hz.id_regaddr2  = r2;
    hz.id_use1      = u1;
    hz.id_use2      = u2;
    hz.id_optype    = 6'($urandom);
    #1;
  endtask

  // One clock: check outputs mid-cycle, advance the model, check counters after the edge.
  task automatic step();
    bit lu, mem_hold, branch_flush, load_hold;
    @(negedge clk);
    lu = (hz.alu_optype == OPT_LW) && (hz.alu_regaddr3 != 5'd0) &&
         ((hz.id_use1 && hz.id_regaddr1 == hz.alu_regaddr3) ||
          (hz.id_use2 && hz.id_regaddr2 == hz.alu_regaddr3));
    mem_hold     = !rst && hz.mem_busy;
    branch_flush = !rst && !hz.mem_busy &&
                   (m_waiting ? m_branch_owed : (!m_flushing && hz.br_taken));
    load_hold    = !rst && !hz.mem_busy && !m_waiting && !m_flushing && !hz.br_taken && lu;
    check_val("pc_stall",   32'(hz.pc_stall),   32'(mem_hold || load_hold));
    check_val("id_stall",   32'(hz.id_stall),   32'(mem_hold || load_hold));
    check_val("alu_stall",  32'(hz.alu_stall),  32'(mem_hold));
    check_val("id_bubble",  32'(hz.id_bubble),  32'(branch_flush));
    check_val("alu_bubble", 32'(hz.alu_bubble), 32'(branch_flush || load_hold));
    check_val("mem_bubble", 32'(hz.mem_bubble), 32'(mem_hold));
    @(posedge clk);
    if (rst) begin
      m_waiting = 0; m_flushing = 0; m_branch_owed = 0;
      m_stall = 32'd0; m_flush = 16'd0;
    end else begin
      if (hz.stall_cnt_load) m_stall = hz.stall_cnt_load_val;
      else if ((mem_hold || load_hold) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (branch_flush && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
      if (mem_hold) begin
        m_branch_owed = m_waiting ? (m_branch_owed | hz.br_taken)
                                  : (m_flushing ? 1'b0 : hz.br_taken);
        m_waiting  = 1;
        m_flushing = 0;
      end else begin
        m_waiting     = 0;
        m_flushing    = branch_flush;
        m_branch_owed = 0;
      end
    end
    #1;
    check_val("stall_cnt", stall_cnt, m_stall);
    check_val("flush_cnt", 32'(flush_cnt), 32'(m_flush));
  endtask

  task automatic reset_dut();
    drive(1, 0, 0, OPT_NOP, 5'd0, 5'd0, 5'd0, 0, 0);
    step();
  endtask

  initial begin
    m_waiting = 0; m_flushing = 0; m_branch_owed = 0;
    m_stall = 32'd0; m_flush = 16'd0;
    hz.stall_cnt_load     = 1'b0;
    hz.stall_cnt_load_val = 32'd0;

    // Reset masks every hazard input.
    drive(1, 1, 1, OPT_LW, 5'd5, 5'd5, 5'd5, 1, 1);
    check_val("rst_pc_stall",   32'(hz.pc_stall), 32'd0);
    check_val("rst_mem_bubble", 32'(hz.mem_bubble), 32'd0);
    check_val("rst_id_bubble",  32'(hz.id_bubble), 32'd0);
    step();
    check_val("rst_stall_cnt", stall_cnt, 32'd0);
    check_val("rst_flush_cnt", 32'(flush_cnt), 32'd0);

    // Load-use on r5.
    drive(0, 0, 0, OPT_LW, 5'd5, 5'd5, 5'd0, 1, 0);
    check_val("lu_pc_stall",   32'(hz.pc_stall), 32'd1);
    check_val("lu_id_stall",   32'(hz.id_stall), 32'd1);
    check_val("lu_alu_bubble", 32'(hz.alu_bubble), 32'd1);
    check_val("lu_alu_stall",  32'(hz.alu_stall), 32'd0);
    step();
    drive(0, 0, 0, OPT_NOP, 5'd0, 5'd5, 5'd0, 1, 0);
    check_val("lu_after_pc_stall", 32'(hz.pc_stall), 32'd0);
    step();
    check_val("lu_stall_cnt", stall_cnt, 32'd1);

    // Load into r0 is not a hazard.
    drive(0, 0, 0, OPT_LW, 5'd0, 5'd0, 5'd0, 1, 0);
    check_val("r0_pc_stall",   32'(hz.pc_stall), 32'd0);
    check_val("r0_alu_bubble", 32'(hz.alu_bubble), 32'd0);
    step();
    check_val("r0_stall_cnt", stall_cnt, 32'd1);

    // Taken branch held two cycles: only the first flushes.
    reset_dut();
    drive(0, 0, 1, OPT_NOP, 5'd0, 5'd0, 5'd0, 0, 0);
    check_val("br_id_bubble",  32'(hz.id_bubble), 32'd1);
    check_val("br_alu_bubble", 32'(hz.alu_bubble), 32'd1);
    check_val("br_pc_stall",   32'(hz.pc_stall), 32'd0);
    step();
    drive(0, 0, 1, OPT_NOP, 5'd0, 5'd0, 5'd0, 0, 0);
    check_val("br2_id_bubble", 32'(hz.id_bubble), 32'd0);
    step();
    check_val("br_flush_cnt", 32'(flush_cnt), 32'd1);
    drive(0, 0, 0, OPT_NOP, 5'd0, 5'd0, 5'd0, 0, 0);
    step();

    // Branch resolved during a 3-cycle memory wait.
    reset_dut();
    drive(0, 1, 1, OPT_NOP, 5'd0, 5'd0, 5'd0, 0, 0);
    check_val("mw_mem_bubble", 32'(hz.mem_bubble), 32'd1);
    check_val("mw_alu_stall",  32'(hz.alu_stall), 32'd1);
    check_val("mw_id_bubble",  32'(hz.id_bubble), 32'd0);
    step();
    drive(0, 1, 0, OPT_NOP, 5'd0, 5'd0, 5'd0, 0, 0);
    step();
    step();
    drive(0, 0, 0, OPT_NOP, 5'd0, 5'd0, 5'd0, 0, 0);
    check_val("mw_flush_id_bubble", 32'(hz.id_bubble), 32'd1);
    check_val("mw_flush_pc_stall",  32'(hz.pc_stall), 32'd0);
    step();
    check_val("mw_post_id_bubble", 32'(hz.id_bubble), 32'd0);
    step();
    check_val("mw_stall_cnt", stall_cnt, 32'd3);
    check_val("mw_flush_cnt", 32'(flush_cnt), 32'd1);

    // Reset while a branch is pending in memory wait.
    reset_dut();
    drive(0, 1, 1, OPT_NOP, 5'd0, 5'd0, 5'd0, 0, 0);
    step();
    drive(1, 1, 0, OPT_NOP, 5'd0, 5'd0, 5'd0, 0, 0);
    check_val("rm_pc_stall", 32'(hz.pc_stall), 32'd0);
    step();
    drive(0, 0, 0, OPT_NOP, 5'd0, 5'd0, 5'd0, 0, 0);
    check_val("rm_id_bubble", 32'(hz.id_bubble), 32'd0);
    step();
    check_val("rm_stall_cnt", stall_cnt, 32'd0);
    check_val("rm_flush_cnt", 32'(flush_cnt), 32'd0);

    // Stall counter saturation.
    reset_dut();
    hz.stall_cnt_load     = 1'b1;
    hz.stall_cnt_load_val = 32'hFFFF_FFFE;
    drive(0, 0, 0, OPT_NOP, 5'd0, 5'd0, 5'd0, 0, 0);
    step();
    hz.stall_cnt_load = 1'b0;
    drive(0, 1, 0, OPT_NOP, 5'd0, 5'd0, 5'd0, 0, 0);
    step();
    step();
    step();
    check_val("sat_stall_cnt", stall_cnt, 32'hFFFF_FFFF);
    drive(0, 0, 0, OPT_NOP, 5'd0, 5'd0, 5'd0, 0, 0);
    step();

    // Random traffic with memory bursts, branches, dense register reuse and rare resets.
    begin
      int burst;
      burst = 0;
      for (int i = 0; i < 3000; i++) begin
        bit r, mb, bt, u1, u2;
        logic [5:0] aop;
        logic [4:0] r1, r2, r3;
        if (burst > 0) begin
          mb = 1; burst--;
        end else if ($urandom_range(0, 9) == 0) begin
          mb = 1; burst = int'($urandom_range(0, 3));
        end else begin
          mb = 0;
        end
        r   = ($urandom_range(0, 149) == 0);
        bt  = ($urandom_range(0, 4) == 0);
        aop = ($urandom_range(0, 1) == 1) ? OPT_LW : 6'($urandom);
        r1  = 5'($urandom_range(0, 3));
        r2  = 5'($urandom_range(0, 3));
        r3  = 5'($urandom_range(0, 3));
        u1  = 1'($urandom);
        u2  = 1'($urandom);
        hz.stall_cnt_load     = ($urandom_range(0, 199) == 0);
        hz.stall_cnt_load_val = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
        drive(r, mb, bt, aop, r3, r1, r2, u1, u2);
        step();
      end
      hz.stall_cnt_load = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
